// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter using the shift-add-3 (double dabble) method,
// one input bit per clock, producing packed BCD digits for the display digit mux.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter bit AUTO   = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // The digit field must hold the largest binary input without truncation.
  if (64'(10) ** DIGITS <= (64'(1) << BIN_W) - 64'(1)) begin : g_digits_too_few
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // A BCD nibble of 5..9 becomes 8..12 so the following doubling carries correctly.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   last_bin_q, last_bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    sreg_q, sreg_d;
  logic [SR_W-1:0]    adj;
  logic [SR_W-1:0]    shifted;
  logic               go;

  always_comb begin
    adj = sreg_q;
    for (int i = 0; i < DIGITS; i++) begin
      adj[BIN_W + 4*i +: 4] = add3(sreg_q[BIN_W + 4*i +: 4]);
    end
    shifted = {adj[SR_W-2:0], 1'b0};
  end

  assign go = start | (AUTO & (bin_in != last_bin_q));

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    last_bin_d = last_bin_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          sreg_d     = {{BCD_W{1'b0}}, bin_in};
          last_bin_d = bin_in;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d = shifted;
        cnt_d  = cnt_q + CNT_W'(1);
        // Last input bit just entered the digit field: publish the result.
        if (cnt_q == LAST_CNT) begin
          bcd_d   = shifted[SR_W-1 -: BCD_W];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible outputs: asynchronous reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      last_bin_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      last_bin_q <= last_bin_d;
      cnt_q      <= cnt_d;
    end
  end

  // Working shift register is always reloaded before use, so it needs no reset.
  always_ff @(posedge sys_clk) begin
    sreg_q <= sreg_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule
